// File: rtl/exec_writeback.sv
// exec_writeback -- retire end of the ALU result path.
//   Completed micro-op results arrive from execute over valid/ready and are held in
//   order in a small FIFO. One entry retires per cycle into the register-file write
//   port and the architectural RFLAGS register, unless the RF port is stalled.
//
// Ports
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_in_valid         result offered by execute
//   o_in_ready         result accepted when valid && ready (occupancy < DEPTH)
//   i_in_has_dst       result writes a GPR (0 for cmp/test-style ops)
//   i_in_dst, i_in_val destination index and value
//   i_in_flags         {of,af,pf,sf,zf,cf}
//   i_in_wr_flags      op updates RFLAGS
//   i_stall            RF write port unavailable; no retire this cycle
//   o_rf_we/idx/wdata/wflags  RF write port
//   o_flags_q          architectural RFLAGS
//   o_retire           one pulse per retired entry
//   o_occupancy        entries held
//
// Build option
//   WB_BYPASS_EN  when defined, a result offered while the FIFO is empty and the RF
//                 port is free retires in the same cycle without being enqueued.
module exec_writeback #(
  parameter int DEPTH     = 4,
  parameter int REG_IDX_W = 4,
  parameter int VAL_W     = 64
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic                         i_in_has_dst,
  input  logic [REG_IDX_W-1:0]         i_in_dst,
  input  logic [VAL_W-1:0]             i_in_val,
  input  logic [5:0]                   i_in_flags,
  input  logic                         i_in_wr_flags,
  input  logic                         i_stall,
  output logic                         o_rf_we,
  output logic [REG_IDX_W-1:0]         o_rf_idx,
  output logic [VAL_W-1:0]             o_rf_wdata,
  output logic [5:0]                   o_rf_wflags,
  output logic [5:0]                   o_flags_q,
  output logic                         o_retire,
  output logic [$clog2(DEPTH+1)-1:0]   o_occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic                 has_dst;
    logic [REG_IDX_W-1:0] dst;
    logic [VAL_W-1:0]     val;
    logic [5:0]           flags;
    logic                 wr_flags;
  } wb_entry_t;

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic [5:0]       r_flags;

  wb_entry_t w_head, w_in;
  logic      w_push, w_pop, w_bypass;

  assign w_head = r_mem[r_rd_ptr];
  assign w_in   = '{has_dst: i_in_has_dst, dst: i_in_dst, val: i_in_val,
                    flags: i_in_flags, wr_flags: i_in_wr_flags};

  // Ready comes from registered occupancy only; a pop in the same cycle does not
  // open a slot until the next cycle.
  assign o_in_ready = (r_occ < OCC_W'(DEPTH));
  assign w_pop      = (r_occ != '0) && !i_stall;

`ifdef WB_BYPASS_EN
  assign w_bypass = (r_occ == '0) && !i_stall && i_in_valid;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed result is consumed directly and never occupies a slot.
  assign w_push = i_in_valid && o_in_ready && !w_bypass;

  always_comb begin
    o_rf_we     = 1'b0;
    o_rf_idx    = '0;
    o_rf_wdata  = '0;
    o_rf_wflags = '0;
    o_retire    = 1'b0;
    if (w_pop) begin
      o_rf_we     = w_head.has_dst;
      o_rf_idx    = w_head.dst;
      o_rf_wdata  = w_head.val;
      o_rf_wflags = w_head.flags;
      o_retire    = 1'b1;
    end else if (w_bypass) begin
      o_rf_we     = w_in.has_dst;
      o_rf_idx    = w_in.dst;
      o_rf_wdata  = w_in.val;
      o_rf_wflags = w_in.flags;
      o_retire    = 1'b1;
    end
  end

  // Storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_flags  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      if (w_pop && w_head.wr_flags)
        r_flags <= w_head.flags;
      else if (w_bypass && w_in.wr_flags)
        r_flags <= w_in.flags;
    end
  end

  assign o_flags_q   = r_flags;
  assign o_occupancy = r_occ;

endmodule

// File: tb/tb_exec_writeback.sv
// Directed bench for exec_writeback (default DEPTH=4, REG_IDX_W=4, VAL_W=64).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_exec_writeback;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_in_valid;
  logic        o_in_ready;
  logic        i_in_has_dst;
  logic [3:0]  i_in_dst;
  logic [63:0] i_in_val;
  logic [5:0]  i_in_flags;
  logic        i_in_wr_flags;
  logic        i_stall;
  logic        o_rf_we;
  logic [3:0]  o_rf_idx;
  logic [63:0] o_rf_wdata;
  logic [5:0]  o_rf_wflags;
  logic [5:0]  o_flags_q;
  logic        o_retire;
  logic [2:0]  o_occupancy;

  int n_chk  = 0;
  int n_fail = 0;
  logic [5:0] m_flags;

  exec_writeback dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_has_dst(i_in_has_dst), .i_in_dst(i_in_dst), .i_in_val(i_in_val),
    .i_in_flags(i_in_flags), .i_in_wr_flags(i_in_wr_flags), .i_stall(i_stall),
    .o_rf_we(o_rf_we), .o_rf_idx(o_rf_idx), .o_rf_wdata(o_rf_wdata),
    .o_rf_wflags(o_rf_wflags), .o_flags_q(o_flags_q), .o_retire(o_retire),
    .o_occupancy(o_occupancy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic has, input logic [3:0] dst,
                       input logic [63:0] val, input logic [5:0] fl, input logic wf);
    i_in_valid    = v;
    i_in_has_dst  = has;
    i_in_dst      = dst;
    i_in_val      = val;
    i_in_flags    = fl;
    i_in_wr_flags = wf;
  endtask

  // Offer one result into an empty, unstalled block and check its retirement.
  task automatic wb_one(input string tag, input logic has, input logic [3:0] dst,
                        input logic [63:0] val, input logic [5:0] fl, input logic wf);
    drive(1'b1, has, dst, val, fl, wf);
`ifndef WB_BYPASS_EN
    #4;
    chk({tag, "_early_ret"}, 64'(o_retire), 64'd0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 64'd0, 6'd0, 1'b0);
`endif
    #4;
    chk({tag, "_ret"},    64'(o_retire),    64'd1);
    chk({tag, "_we"},     64'(o_rf_we),     64'(has));
    chk({tag, "_idx"},    64'(o_rf_idx),    64'(dst));
    chk({tag, "_wdata"},  64'(o_rf_wdata),  val);
    chk({tag, "_wflags"}, 64'(o_rf_wflags), 64'(fl));
    tick();
    drive(1'b0, 1'b0, 4'd0, 64'd0, 6'd0, 1'b0);
    if (wf) m_flags = fl;
    chk({tag, "_flags_q"}, 64'(o_flags_q),   64'(m_flags));
    chk({tag, "_occ"},     64'(o_occupancy), 64'd0);
  endtask

  initial begin
    int exp_next;
    i_rst_n = 1'b0;
    i_stall = 1'b0;
    m_flags = 6'h00;
    drive(1'b0, 1'b0, 4'd0, 64'd0, 6'd0, 1'b0);
    tick(); tick();
    i_rst_n = 1'b1;
    #4;
    chk("rst_ready", 64'(o_in_ready),  64'd1);
    chk("rst_occ",   64'(o_occupancy), 64'd0);
    chk("rst_flags", 64'(o_flags_q),   64'd0);
    chk("rst_we",    64'(o_rf_we),     64'd0);
    chk("rst_ret",   64'(o_retire),    64'd0);
    tick();

    // 1: single result with GPR write and flags update
    wb_one("t1", 1'b1, 4'd3, 64'h1234, 6'h05, 1'b1);

    // 2: fill while stalled, then drain in order
    i_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b1, 4'(i), 64'(100 + i), 6'h00, 1'b0);
      #4;
      chk("t2_fill_ready", 64'(o_in_ready), 64'd1);
      chk("t2_fill_we",    64'(o_rf_we),    64'd0);
      tick();
    end
    drive(1'b0, 1'b0, 4'd0, 64'd0, 6'd0, 1'b0);
    #4;
    chk("t2_full_occ",   64'(o_occupancy), 64'd4);
    chk("t2_full_ready", 64'(o_in_ready),  64'd0);
    chk("t2_full_we",    64'(o_rf_we),     64'd0);
    chk("t2_full_wdata", o_rf_wdata,       64'd0);
    tick();
    i_stall = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #4;
      chk("t2_idx",   64'(o_rf_idx),   64'(k));
      chk("t2_wdata", o_rf_wdata,      64'(100 + k));
      chk("t2_we",    64'(o_rf_we),    64'd1);
      chk("t2_ready", 64'(o_in_ready), (k == 1) ? 64'd0 : 64'd1);
      tick();
    end
    chk("t2_occ_end", 64'(o_occupancy), 64'd0);
    chk("t2_flags",   64'(o_flags_q),   64'h05);

    // 3: flags-only op
    wb_one("t3", 1'b0, 4'd9, 64'hdead, 6'h02, 1'b1);
    // 4: GPR write that leaves RFLAGS alone
    wb_one("t4", 1'b1, 4'd5, 64'hbeef, 6'h3f, 1'b0);

    // 5: reset discards held entries
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 4'(10 + i), 64'(i), 6'h11, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 4'd0, 64'd0, 6'd0, 1'b0);
    #4;
    chk("t5_occ_held", 64'(o_occupancy), 64'd3);
    tick();
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    m_flags = 6'h00;
    #4;
    chk("t5_occ",   64'(o_occupancy), 64'd0);
    chk("t5_flags", 64'(o_flags_q),   64'd0);
    chk("t5_ready", 64'(o_in_ready),  64'd1);
    tick();
    i_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #4;
      chk("t5_no_we",  64'(o_rf_we),  64'd0);
      chk("t5_no_ret", 64'(o_retire), 64'd0);
      tick();
    end

    // 6: single push latency, then a continuous stream across pointer wrap
    wb_one("t6", 1'b1, 4'd7, 64'h77, 6'h00, 1'b0);
    exp_next = 0;
    for (int c = 0; c < 12; c++) begin
      drive(c < 10, 1'b1, 4'(c), 64'(c), 6'h00, 1'b0);
      #4;
      if (o_rf_we) begin
        chk("t6_stream_idx",   64'(o_rf_idx), 64'(exp_next));
        chk("t6_stream_wdata", o_rf_wdata,    64'(exp_next));
        exp_next++;
      end
      chk("t6_stream_occ", 64'(o_occupancy <= 3'd1), 64'd1);
      tick();
    end
    drive(1'b0, 1'b0, 4'd0, 64'd0, 6'd0, 1'b0);
    chk("t6_stream_cnt", 64'(exp_next), 64'd10);
    chk("t6_stream_occ_end", 64'(o_occupancy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
